// File: rtl/btn_pkg.sv
// Shared constants, FSM state type and encode helpers for the button scan encoder.
package btn_pkg;

  localparam int unsigned NUM_BTN = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned POP_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    RELEASE = 2'd2
  } btn_state_e;

  // Highest set bit wins; bit 7 maps to index 0.
  function automatic logic [IDX_W-1:0] prio_idx(input logic [NUM_BTN-1:0] lvl);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (lvl[i]) r = IDX_W'(NUM_BTN - 1 - i);
    end
    return r;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [NUM_BTN-1:0] lvl);
    logic [POP_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      c = c + POP_W'(lvl[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/btn_scan_encoder_if.sv
// Button pins in, debounced level / encoded index / strobes out.
interface btn_scan_encoder_if;
  import btn_pkg::*;

  logic [NUM_BTN-1:0] btn;
  logic [NUM_BTN-1:0] btn_level;
  logic [IDX_W-1:0]   idx;
  logic               idx_valid;
  logic               press_pulse;
  logic               release_pulse;
  logic               multi;

  modport master (
    output btn,
    input  btn_level, idx, idx_valid, press_pulse, release_pulse, multi
  );

  modport slave (
    input  btn,
    output btn_level, idx, idx_valid, press_pulse, release_pulse, multi
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: pin polarity, 2-flop synchronizer, tick-sampled history, debounced level.
// Optional BTN_ACTIVE_LOW_EN: pin low means pressed.
module btn_debounce_ch #(
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o
);

  logic                      pin_c;
  logic                      sync1_q, sync2_q;
  logic [STABLE_SAMPLES-1:0] hist_q, hist_d;
  logic                      level_q, level_d;

`ifdef BTN_ACTIVE_LOW_EN
  assign pin_c = ~btn_i;
`else
  assign pin_c = btn_i;
`endif

  // Level only moves once every sample in the window agrees on the new value.
  always_comb begin
    hist_d  = hist_q;
    level_d = level_q;
    if (tick_i) hist_d = STABLE_SAMPLES'({hist_q, sync2_q});
    if ((&hist_q) && !level_q) level_d = 1'b1;
    if (!(|hist_q) && level_q) level_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= pin_c;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/btn_scan_encoder.sv
// Debounced 8-button scanner with priority index latch and press/release strobes.
// Optional BTN_ACTIVE_LOW_EN (in btn_debounce_ch): active-low button pins.
module btn_scan_encoder
  import btn_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  btn_scan_encoder_if.slave bus
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_c;
  logic [NUM_BTN-1:0] level_c;

  btn_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               idx_valid_q, idx_valid_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               multi_q, multi_d;

  // Sample tick shared by all channels.
  assign tick_c = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_i (tick_c),
      .btn_i  (bus.btn[g]),
      .level_o(level_c[g])
    );
  end

  // Index is captured only on the IDLE->PRESSED edge and held otherwise.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    idx_valid_d = 1'b0;
    press_d     = 1'b0;
    release_d   = 1'b0;
    multi_d     = (popcount(level_c) > POP_W'(1));
    case (state_q)
      IDLE: begin
        if (level_c != '0) begin
          state_d = PRESSED;
          idx_d   = prio_idx(level_c);
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (level_c == '0) begin
          state_d   = RELEASE;
          release_d = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    idx_valid_d = (state_d == PRESSED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      state_q     <= IDLE;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      press_q     <= press_d;
      release_q   <= release_d;
      multi_q     <= multi_d;
    end
  end

  assign bus.btn_level     = level_c;
  assign bus.idx           = idx_q;
  assign bus.idx_valid     = idx_valid_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.multi         = multi_q;

endmodule

// File: tb/tb_btn_scan_encoder.sv
// Directed bench for btn_scan_encoder with TICK_DIV=4, STABLE_SAMPLES=3.
module tb_btn_scan_encoder;
  import btn_pkg::*;

  localparam int unsigned TD      = 4;
  localparam int unsigned SS      = 3;
  localparam int          LAT_MAX = 2 + SS * TD + 2;
`ifdef BTN_ACTIVE_LOW_EN
  localparam logic [7:0] REL = 8'hFF;
`else
  localparam logic [7:0] REL = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  btn_scan_encoder_if bus ();

  btn_scan_encoder #(
    .TICK_DIV      (TD),
    .STABLE_SAMPLES(SS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         press_cnt;
  int         rel_cnt;
  int         first_press;
  int         cyc;
  logic [7:0] lvl_or;

  task automatic clr_counts();
    press_cnt   = 0;
    rel_cnt     = 0;
    first_press = -1;
    cyc         = 0;
    lvl_or      = '0;
  endtask

  // Advance n cycles, sampling on the falling edge and tallying strobes.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.press_pulse) begin
        press_cnt++;
        if (first_press < 0) first_press = cyc;
      end
      if (bus.release_pulse) rel_cnt++;
      lvl_or = lvl_or | bus.btn_level;
    end
  endtask

  task automatic drive(input logic [7:0] pressed);
    bus.btn = pressed ^ REL;
  endtask

  task automatic test_reset();
    drive(8'h00);
    rst_n = 1'b0;
    clr_counts();
    run(3);
    total++; if (bus.btn_level !== 8'h00) begin bad++; $display("FAIL rst_level: got %0h want 0", bus.btn_level); end
    total++; if (bus.idx !== 3'd0) begin bad++; $display("FAIL rst_idx: got %0d want 0", bus.idx); end
    total++; if (bus.idx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", bus.idx_valid); end
    total++; if (bus.press_pulse !== 1'b0 || bus.release_pulse !== 1'b0) begin bad++; $display("FAIL rst_pulses: got %0b%0b want 00", bus.press_pulse, bus.release_pulse); end
    total++; if (bus.multi !== 1'b0) begin bad++; $display("FAIL rst_multi: got %0b want 0", bus.multi); end
    rst_n = 1'b1;
    run(20);
    total++; if (press_cnt !== 0 || bus.idx_valid !== 1'b0) begin bad++; $display("FAIL idle_after_rst: got press=%0d valid=%0b want 0 0", press_cnt, bus.idx_valid); end
  endtask

  task automatic test_clean_press();
    clr_counts();
    drive(8'h10);
    run(40);
    total++; if (bus.btn_level !== 8'h10) begin bad++; $display("FAIL clean_level: got %0h want 10", bus.btn_level); end
    total++; if (bus.idx !== 3'd3) begin bad++; $display("FAIL clean_idx: got %0d want 3", bus.idx); end
    total++; if (bus.idx_valid !== 1'b1) begin bad++; $display("FAIL clean_valid: got %0b want 1", bus.idx_valid); end
    total++; if (press_cnt !== 1) begin bad++; $display("FAIL clean_press_cnt: got %0d want 1", press_cnt); end
    total++; if (first_press < 1 || first_press > LAT_MAX) begin bad++; $display("FAIL clean_latency: got %0d want 1..%0d", first_press, LAT_MAX); end
    total++; if (bus.multi !== 1'b0) begin bad++; $display("FAIL clean_multi: got %0b want 0", bus.multi); end
    clr_counts();
    drive(8'h00);
    run(40);
    total++; if (rel_cnt !== 1) begin bad++; $display("FAIL clean_rel_cnt: got %0d want 1", rel_cnt); end
    total++; if (press_cnt !== 0) begin bad++; $display("FAIL clean_rel_press: got %0d want 0", press_cnt); end
    total++; if (bus.idx_valid !== 1'b0 || bus.btn_level !== 8'h00) begin bad++; $display("FAIL clean_idle: got valid=%0b level=%0h want 0 0", bus.idx_valid, bus.btn_level); end
    total++; if (bus.idx !== 3'd3) begin bad++; $display("FAIL clean_idx_hold: got %0d want 3", bus.idx); end
  endtask

  task automatic test_bounce();
    clr_counts();
    for (int k = 0; k < 12; k++) begin
      drive((k % 2 == 0) ? 8'h01 : 8'h00);
      run(5);
    end
    drive(8'h00);
    run(20);
    total++; if (lvl_or !== 8'h00) begin bad++; $display("FAIL bounce_level: got %0h want 0", lvl_or); end
    total++; if (press_cnt !== 0 || rel_cnt !== 0) begin bad++; $display("FAIL bounce_pulses: got press=%0d rel=%0d want 0 0", press_cnt, rel_cnt); end
  endtask

  task automatic test_simultaneous();
    clr_counts();
    drive(8'h41);
    run(40);
    total++; if (bus.btn_level !== 8'h41) begin bad++; $display("FAIL sim_level: got %0h want 41", bus.btn_level); end
    total++; if (bus.idx !== 3'd1) begin bad++; $display("FAIL sim_idx: got %0d want 1", bus.idx); end
    total++; if (bus.multi !== 1'b1) begin bad++; $display("FAIL sim_multi: got %0b want 1", bus.multi); end
    total++; if (press_cnt !== 1) begin bad++; $display("FAIL sim_press_cnt: got %0d want 1", press_cnt); end
    clr_counts();
    drive(8'h00);
    run(40);
    total++; if (rel_cnt !== 1 || bus.multi !== 1'b0) begin bad++; $display("FAIL sim_release: got rel=%0d multi=%0b want 1 0", rel_cnt, bus.multi); end
  endtask

  task automatic test_late_press();
    clr_counts();
    drive(8'h01);
    run(30);
    total++; if (bus.idx !== 3'd7 || bus.idx_valid !== 1'b1) begin bad++; $display("FAIL late_first_idx: got %0d/%0b want 7/1", bus.idx, bus.idx_valid); end
    total++; if (press_cnt !== 1 || bus.multi !== 1'b0) begin bad++; $display("FAIL late_first: got press=%0d multi=%0b want 1 0", press_cnt, bus.multi); end
    clr_counts();
    drive(8'h81);
    run(30);
    total++; if (bus.btn_level !== 8'h81) begin bad++; $display("FAIL late_level: got %0h want 81", bus.btn_level); end
    total++; if (bus.idx !== 3'd7) begin bad++; $display("FAIL late_idx_hold: got %0d want 7", bus.idx); end
    total++; if (bus.multi !== 1'b1) begin bad++; $display("FAIL late_multi: got %0b want 1", bus.multi); end
    total++; if (press_cnt !== 0 || rel_cnt !== 0) begin bad++; $display("FAIL late_pulses: got press=%0d rel=%0d want 0 0", press_cnt, rel_cnt); end
    clr_counts();
    drive(8'h00);
    run(40);
    total++; if (rel_cnt !== 1) begin bad++; $display("FAIL late_rel_cnt: got %0d want 1", rel_cnt); end
  endtask

  task automatic test_mid_reset();
    clr_counts();
    drive(8'h10);
    run(30);
    total++; if (bus.idx_valid !== 1'b1) begin bad++; $display("FAIL mrst_pre_valid: got %0b want 1", bus.idx_valid); end
    clr_counts();
    rst_n = 1'b0;
    #1;
    total++; if (bus.btn_level !== 8'h00 || bus.idx !== 3'd0 || bus.idx_valid !== 1'b0) begin bad++; $display("FAIL mrst_async_clear: got level=%0h idx=%0d valid=%0b want 0 0 0", bus.btn_level, bus.idx, bus.idx_valid); end
    total++; if (bus.release_pulse !== 1'b0 || bus.multi !== 1'b0) begin bad++; $display("FAIL mrst_async_pulse: got rel=%0b multi=%0b want 0 0", bus.release_pulse, bus.multi); end
    run(3);
    rst_n = 1'b1;
    run(30);
    total++; if (rel_cnt !== 0) begin bad++; $display("FAIL mrst_no_release: got %0d want 0", rel_cnt); end
    total++; if (press_cnt !== 1) begin bad++; $display("FAIL mrst_repress: got %0d want 1", press_cnt); end
    total++; if (bus.idx !== 3'd3 || bus.idx_valid !== 1'b1) begin bad++; $display("FAIL mrst_idx: got %0d/%0b want 3/1", bus.idx, bus.idx_valid); end
    clr_counts();
    drive(8'h00);
    run(40);
    total++; if (rel_cnt !== 1) begin bad++; $display("FAIL mrst_final_rel: got %0d want 1", rel_cnt); end
  endtask

`ifdef BTN_ACTIVE_LOW_EN
  task automatic test_active_low();
    clr_counts();
    bus.btn = 8'hFE;
    run(30);
    total++; if (bus.btn_level !== 8'h01) begin bad++; $display("FAIL al_level: got %0h want 01", bus.btn_level); end
    total++; if (bus.idx !== 3'd7 || press_cnt !== 1) begin bad++; $display("FAIL al_idx: got idx=%0d press=%0d want 7 1", bus.idx, press_cnt); end
    bus.btn = 8'hFF;
    run(40);
  endtask
`endif

  initial begin
    bus.btn = REL;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_late_press();
    test_mid_reset();
`ifdef BTN_ACTIVE_LOW_EN
    test_active_low();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
